// File: rtl/soc_system_i2c_target.sv
// soc_system_i2c_target: I2C target over an 8-byte register bank shared with an Avalon-MM slave
module soc_system_i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h68,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl,
  inout  wire         sda,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        busy
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_dly_q, sda_dly_q;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] ptr_q, ptr_d;
  logic rw_q, rw_d, drv_q, drv_d, sda_oe_q;
  logic [7:0] regs_q [8];
  logic wr_en;
  logic [7:0] wr_byte, rd_byte;
  logic scl_s, sda_s, scl_rise, scl_fall, start, stop;
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:8];
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_dly_q;
  assign scl_fall = ~scl_s & scl_dly_q;
  assign start = scl_s & sda_dly_q & ~sda_s;
  assign stop = scl_s & ~sda_dly_q & sda_s;
  assign rd_byte = regs_q[ptr_q];
  assign busy = state_q != IDLE;
  assign sda = sda_oe_q ? 1'b0 : 1'bz;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q <= 1'b1;
      sda_dly_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      scl_dly_q <= scl_s;
      sda_dly_q <= sda_s;
    end
  end
  // Bus conditions take priority over any SCL edge seen in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    ptr_d = ptr_q;
    rw_d = rw_q;
    drv_d = drv_q;
    wr_en = 1'b0;
    wr_byte = {sh_q[6:0], sda_s};
    if (stop) begin
      state_d = IDLE;
      drv_d = 1'b0;
    end else if (start) begin
      state_d = ADDR;
      cnt_d = '0;
      drv_d = 1'b0;
    end else if (scl_rise) begin
      if (state_q == ADDR || state_q == PTR || state_q == WDATA) begin
        sh_d = wr_byte;
        cnt_d = cnt_q + 4'd1;
      end
      if (state_q == WDATA && cnt_q == 4'd7) begin
        wr_en = 1'b1;
        ptr_d = ptr_q + 3'd1;
      end
      if (state_q == RDATA_ACK && sda_s) state_d = WAIT_STOP;
    end else if (scl_fall) begin
      case (state_q)
        ADDR: if (cnt_q == 4'd8) begin
          cnt_d = '0;
          rw_d = sh_q[0];
          drv_d = sh_q[7:1] == TARGET_ADDR;
          state_d = sh_q[7:1] == TARGET_ADDR ? ADDR_ACK : WAIT_STOP;
        end
        ADDR_ACK: begin
          drv_d = rw_q ? ~rd_byte[7] : 1'b0;
          sh_d = rw_q ? {rd_byte[6:0], 1'b0} : sh_q;
          cnt_d = rw_q ? 4'd1 : cnt_q;
          state_d = rw_q ? RDATA : PTR;
        end
        PTR: if (cnt_q == 4'd8) begin
          ptr_d = sh_q[2:0];
          cnt_d = '0;
          drv_d = 1'b1;
          state_d = PTR_ACK;
        end
        PTR_ACK, WDATA_ACK: begin
          drv_d = 1'b0;
          state_d = WDATA;
        end
        WDATA: if (cnt_q == 4'd8) begin
          cnt_d = '0;
          drv_d = 1'b1;
          state_d = WDATA_ACK;
        end
        RDATA: if (cnt_q == 4'd8) begin
          cnt_d = '0;
          drv_d = 1'b0;
          ptr_d = ptr_q + 3'd1;
          state_d = RDATA_ACK;
        end else begin
          drv_d = ~sh_q[7];
          sh_d = {sh_q[6:0], 1'b0};
          cnt_d = cnt_q + 4'd1;
        end
        RDATA_ACK: begin
          drv_d = ~rd_byte[7];
          sh_d = {rd_byte[6:0], 1'b0};
          cnt_d = 4'd1;
          state_d = RDATA;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      ptr_q <= '0;
      rw_q <= 1'b0;
      drv_q <= 1'b0;
      sda_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      ptr_q <= ptr_d;
      rw_q <= rw_d;
      drv_q <= drv_d;
      sda_oe_q <= drv_q;
    end
  end
  // The Avalon write is issued last so it wins a same-register collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
      readdata <= '0;
    end else begin
      if (wr_en) regs_q[ptr_q] <= wr_byte;
      if (chipselect & ~write_n) regs_q[address] <= writedata[7:0];
      readdata <= {24'b0, regs_q[address]};
    end
  end
endmodule

// File: tb/tb_soc_system_i2c_target.sv
// tb_soc_system_i2c_target: scoreboard bench driving an I2C controller model and Avalon accesses
module tb_soc_system_i2c_target;
  localparam int S = 2;
  logic clk = 0, reset = 1, scl = 1, m_sda = 1;
  logic chipselect = 0, write_n = 1, rd_vld = 0, rd_vld_d = 0;
  logic [2:0] address = 0;
  logic [31:0] writedata = 0, readdata;
  logic busy;
  wire sda_w;
  int n_chk = 0, n_fail = 0, cyc = 0, fall_cyc = 0;
  logic sda_prev = 1, m_prev = 1, rst_prev = 1;
  typedef struct {string nm; logic [31:0] v;} exp_t;
  exp_t bit_q[$], rd_q[$];

  pullup (sda_w);
  assign sda_w = m_sda ? 1'bz : 1'b0;

  soc_system_i2c_target #(.TARGET_ADDR(7'h68), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda_w), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_vld_d <= rd_vld;
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic exp_t mk(input string nm, input logic [31:0] v);
    exp_t x;
    x.nm = nm;
    x.v = v;
    return x;
  endfunction

  // Monitors: bus bit at each checked SCL rise, readdata one clk after a read request
  always @(posedge scl) if (bit_q.size() > 0) begin : mon_bit
    exp_t e;
    e = bit_q.pop_front();
    chk(e.nm, {31'b0, sda_w}, e.v);
  end

  always @(negedge clk) if (rd_vld_d) begin : mon_rd
    exp_t e;
    if (rd_q.size() == 0) chk("rd_q_underflow", 32'd1, 32'd0);
    else begin
      e = rd_q.pop_front();
      chk(e.nm, readdata, e.v);
    end
  end

  always @(negedge scl) fall_cyc = cyc;

  // Any SDA change caused by the target must land S+2 clk after the SCL pin fell
  always @(negedge clk) begin
    if (!reset && !rst_prev && m_sda && m_prev && sda_w !== sda_prev) begin
      chk("sda_edge_delay", cyc - fall_cyc, S + 2);
      chk("sda_edge_scl_low", {31'b0, scl}, 32'd0);
    end
    sda_prev = sda_w;
    m_prev = m_sda;
    rst_prev = reset;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_io(input logic b, input logic ck, input logic e, input string nm);
    m_sda = b;
    tick(4);
    if (ck) bit_q.push_back(mk(nm, {31'b0, e}));
    scl = 1;
    tick(8);
    scl = 0;
    tick(4);
  endtask

  task automatic start_c();
    m_sda = 0;
    tick(4);
    scl = 0;
    tick(4);
  endtask

  task automatic rstart();
    m_sda = 1;
    tick(4);
    scl = 1;
    tick(4);
    start_c();
  endtask

  task automatic stop_c();
    m_sda = 0;
    tick(4);
    scl = 1;
    tick(4);
    m_sda = 1;
    tick(8);
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic ack, input string nm);
    for (int i = 7; i >= 0; i--) bit_io(b[i], 0, 0, nm);
    bit_io(1, 1, ack, nm);
  endtask

  task automatic rd_byte(input logic [7:0] e, input logic mack, input string nm);
    for (int i = 7; i >= 0; i--) bit_io(1, 1, e[i], nm);
    bit_io(mack, 0, 0, nm);
  endtask

  task automatic av_wr(input logic [2:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1;
    write_n = 0;
    tick(1);
    chipselect = 0;
    write_n = 1;
  endtask

  task automatic av_rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    address = a;
    rd_vld = 1;
    rd_q.push_back(mk(nm, e));
    tick(1);
    rd_vld = 0;
    tick(1);
  endtask

  // Last data bit with an Avalon write to reg 2 landing on the I2C commit edge
  task automatic coll_byte(input logic [7:0] b);
    for (int i = 7; i >= 1; i--) bit_io(b[i], 0, 0, "co_data");
    m_sda = b[0];
    tick(4);
    scl = 1;
    tick(S);
    address = 2;
    writedata = 32'h11;
    chipselect = 1;
    write_n = 0;
    tick(1);
    chipselect = 0;
    write_n = 1;
    tick(8 - S - 1);
    scl = 0;
    tick(4);
    bit_io(1, 1, 0, "co_data_ack");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    tick(3);
    chk("rst_sda", {31'b0, sda_w}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    reset = 0;
    tick(2);
    // Write A5, 5A starting at reg 3
    start_c();
    wr_byte(8'hD0, 0, "wr_addr_ack");
    wr_byte(8'h03, 0, "wr_ptr_ack");
    wr_byte(8'hA5, 0, "wr_d0_ack");
    wr_byte(8'h5A, 0, "wr_d1_ack");
    stop_c();
    av_rd(3, 32'hA5, "wr_reg3");
    av_rd(4, 32'h5A, "wr_reg4");
    // Pointer write, repeated start, read wrapping 7 -> 0
    av_wr(7, 32'h3C);
    av_wr(0, 32'hC3);
    start_c();
    wr_byte(8'hD0, 0, "rr_addr_ack");
    wr_byte(8'h07, 0, "rr_ptr_ack");
    rstart();
    wr_byte(8'hD1, 0, "rr_raddr_ack");
    rd_byte(8'h3C, 0, "rr_byte7");
    rd_byte(8'hC3, 1, "rr_byte0");
    chk("rr_wait_stop_sda", {31'b0, sda_w}, 32'd1);
    chk("rr_wait_stop_busy", {31'b0, busy}, 32'd1);
    stop_c();
    chk("rr_idle_busy", {31'b0, busy}, 32'd0);
    // Foreign address
    start_c();
    wr_byte(8'hA0, 1, "mm_addr_nack");
    wr_byte(8'h55, 1, "mm_data_nack");
    chk("mm_busy", {31'b0, busy}, 32'd1);
    stop_c();
    chk("mm_idle_busy", {31'b0, busy}, 32'd0);
    av_rd(0, 32'hC3, "mm_reg0");
    av_rd(1, 32'h00, "mm_reg1");
    av_rd(5, 32'h00, "mm_reg5");
    // Collision on reg 2, then read back at ptr 3
    start_c();
    wr_byte(8'hD0, 0, "co_addr_ack");
    wr_byte(8'h02, 0, "co_ptr_ack");
    coll_byte(8'h22);
    rstart();
    wr_byte(8'hD1, 0, "co_raddr_ack");
    rd_byte(8'hA5, 1, "co_ptr3");
    stop_c();
    av_rd(2, 32'h11, "co_reg2");
    // Reset while the target is driving its address ACK
    av_wr(5, 32'h77);
    av_rd(5, 32'h77, "rs_reg5_pre");
    start_c();
    b = 8'hD0;
    for (int i = 7; i >= 0; i--) bit_io(b[i], 0, 0, "rs_addr");
    m_sda = 1;
    tick(4);
    scl = 1;
    tick(4);
    chk("rs_ack_driven", {31'b0, sda_w}, 32'd0);
    reset = 1;
    #1;
    chk("rs_sda_released", {31'b0, sda_w}, 32'd1);
    chk("rs_busy", {31'b0, busy}, 32'd0);
    chk("rs_readdata", readdata, 32'd0);
    tick(2);
    reset = 0;
    tick(8);
    start_c();
    wr_byte(8'hD0, 0, "rs_addr_ack");
    wr_byte(8'h00, 0, "rs_ptr_ack");
    stop_c();
    av_rd(5, 32'h00, "rs_reg5_post");
    chk("queues_empty", bit_q.size() + rd_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
